// File: rtl/ahb_gpio_debounce.sv
// Per-bit GPIO synchroniser, debouncer and edge detector for an AHB GPIO slave.
// Define DEBOUNCE_IRQ_EN to add sticky per-bit edge flags and the IRQ output.
module ahb_gpio_debounce #(
  parameter int WIDTH     = 16,
  parameter int DB_CYCLES = 4
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [WIDTH-1:0] PIN_IN,
  output logic [WIDTH-1:0] GPIOIN,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  input  logic [WIDTH-1:0] IRQ_CLR,
  output logic             IRQ
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  // Any cycle where sync2 agrees with stable restarts the count.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CMAX) begin
          stable_d[i] = sync2_q[i];
          rise_d[i]   = sync2_q[i];
          fall_d[i]   = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= PIN_IN;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign GPIOIN = stable_q;
  assign RISE   = rise_q;
  assign FALL   = fall_q;

`ifdef DEBOUNCE_IRQ_EN
  logic [WIDTH-1:0] flag_q, flag_d;
  logic             irq_q;

  // A new edge beats a coincident clear.
  assign flag_d = (flag_q & ~IRQ_CLR) | rise_q | fall_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      flag_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      irq_q  <= |flag_d;
    end
  end

  assign IRQ = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = ^IRQ_CLR;
  assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_gpio_debounce.sv
// Randomised and directed bench for ahb_gpio_debounce against a run-length model.
// Build with DEBOUNCE_IRQ_EN defined to also exercise the interrupt flags.
module tb_ahb_gpio_debounce;

  localparam int W  = 16;
  localparam int DB = 4;
`ifdef DEBOUNCE_IRQ_EN
  localparam bit IRQ_EXP = 1'b1;
`else
  localparam bit IRQ_EXP = 1'b0;
`endif

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic [W-1:0] PIN_IN;
  logic [W-1:0] IRQ_CLR;
  logic [W-1:0] GPIOIN, RISE, FALL;
  logic         IRQ;

  int errors = 0;
  int checks = 0;

  ahb_gpio_debounce #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PIN_IN(PIN_IN),
    .GPIOIN(GPIOIN), .RISE(RISE), .FALL(FALL),
    .IRQ_CLR(IRQ_CLR), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  // Model: pins seen two edges late, accepted after DB consecutive differing samples.
  logic [W-1:0] m_p1, m_p2, m_st, m_rise, m_fall, m_flag;
  logic         m_irq;
  int           m_run [W];

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_st = '0;
    m_rise = '0; m_fall = '0; m_flag = '0; m_irq = 1'b0;
    for (int b = 0; b < W; b++) m_run[b] = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] s, r, f;
    s = m_p2; r = '0; f = '0;
    for (int b = 0; b < W; b++) begin
      if (s[b] != m_st[b]) begin
        m_run[b] = m_run[b] + 1;
        if (m_run[b] == DB) begin
          m_st[b] = s[b];
          m_run[b] = 0;
          if (s[b]) r[b] = 1'b1; else f[b] = 1'b1;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    if (IRQ_EXP) begin
      m_flag = (m_flag & ~IRQ_CLR) | m_rise | m_fall;
      m_irq = |m_flag;
    end
    m_rise = r; m_fall = f;
    m_p2 = m_p1; m_p1 = PIN_IN;
  endtask

  task automatic tick();
    @(posedge HCLK);
    if (HRESET) model_reset(); else model_edge();
    #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; PIN_IN = '0; IRQ_CLR = '0;
    model_reset();
    repeat (5) tick();
    checks++;
    if ({GPIOIN, RISE, FALL, IRQ} !== '0) begin
      errors++;
      $display("FAIL reset_hold got g=%h r=%h f=%h i=%b want 0", GPIOIN, RISE, FALL, IRQ);
    end
    HRESET = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({GPIOIN, RISE, FALL, IRQ} !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got g=%h r=%h f=%h i=%b want 0", i, GPIOIN, RISE, FALL, IRQ);
      end
    end
  endtask

  task automatic test_step();
    logic [W-1:0] g [13];
    logic [W-1:0] r [13];
    logic         q [13];
    PIN_IN = 16'h0001;
    for (int i = 1; i <= 12; i++) begin
      tick();
      g[i] = GPIOIN; r[i] = RISE; q[i] = IRQ;
    end
    checks++;
    if (g[5] !== 16'h0000 || g[6] !== 16'h0001) begin
      errors++;
      $display("FAIL step_latency got g5=%h g6=%h want 0000 0001", g[5], g[6]);
    end
    checks++;
    if (r[5] !== 16'h0 || r[6] !== 16'h0001 || r[7] !== 16'h0) begin
      errors++;
      $display("FAIL step_rise got r5=%h r6=%h r7=%h want 0000 0001 0000", r[5], r[6], r[7]);
    end
    checks++;
    if (q[6] !== 1'b0 || q[7] !== IRQ_EXP) begin
      errors++;
      $display("FAIL step_irq got q6=%b q7=%b want 0 %b", q[6], q[7], IRQ_EXP);
    end
  endtask

  task automatic test_glitch();
    logic seen;
    int   pulses;
    seen = 1'b0;
    PIN_IN = 16'h0009;
    repeat (3) begin tick(); seen |= GPIOIN[3] | RISE[3]; end
    PIN_IN = 16'h0001;
    tick(); seen |= GPIOIN[3] | RISE[3];
    PIN_IN = 16'h0009;
    repeat (3) begin tick(); seen |= GPIOIN[3] | RISE[3]; end
    PIN_IN = 16'h0001;
    repeat (10) begin tick(); seen |= GPIOIN[3] | RISE[3]; end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reject got seen=%b want 0", seen);
    end
    pulses = 0;
    PIN_IN = 16'h0009;
    repeat (12) begin
      tick();
      if (RISE !== 16'h0) begin
        pulses++;
        checks++;
        if (RISE !== 16'h0008) begin
          errors++;
          $display("FAIL glitch_hold_rise got %h want 0008", RISE);
        end
      end
    end
    checks++;
    if (pulses != 1 || GPIOIN !== 16'h0009) begin
      errors++;
      $display("FAIL glitch_hold got pulses=%0d g=%h want 1 0009", pulses, GPIOIN);
    end
  endtask

  task automatic test_multi();
    int hits;
    PIN_IN = 16'h00F0;
    repeat (10) tick();
    hits = 0;
    PIN_IN = 16'h0F00;
    repeat (10) begin
      tick();
      if (RISE !== 16'h0 || FALL !== 16'h0) begin
        hits++;
        checks++;
        if (RISE !== 16'h0F00 || FALL !== 16'h00F0) begin
          errors++;
          $display("FAIL multi_edges got r=%h f=%h want 0f00 00f0", RISE, FALL);
        end
      end
    end
    checks++;
    if (hits != 1) begin
      errors++;
      $display("FAIL multi_count got %0d pulse cycles want 1", hits);
    end
  endtask

  task automatic test_irq_clr();
    bit found;
    IRQ_CLR = '1; tick(); IRQ_CLR = '0;
    tick();
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear_all got %b want 0", IRQ);
    end
    PIN_IN = 16'h0F01;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin tick(); found = RISE[0]; end
    tick();
    PIN_IN = 16'h0F00;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin tick(); found = FALL[0]; end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL irq_fall_timeout got no FALL[0] want pulse");
    end
    IRQ_CLR = 16'h0001; tick(); IRQ_CLR = '0;
    tick();
    checks++;
    if (IRQ !== IRQ_EXP || IRQ !== m_irq) begin
      errors++;
      $display("FAIL irq_set_wins got %b want %b", IRQ, IRQ_EXP);
    end
    IRQ_CLR = 16'h0001; tick(); IRQ_CLR = '0;
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL irq_lone_clr got %b want 0", IRQ);
    end
  endtask

  task automatic test_reset_midcount();
    int first;
    logic [W-1:0] fv;
    PIN_IN = 16'h0100;
    repeat (10) tick();
    PIN_IN = 16'h0120;
    repeat (4) tick();
    #1 HRESET = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({GPIOIN, RISE, FALL, IRQ} !== '0) begin
      errors++;
      $display("FAIL midreset_async got g=%h r=%h f=%h i=%b want 0", GPIOIN, RISE, FALL, IRQ);
    end
    repeat (2) tick();
    HRESET = 1'b0;
    first = 0; fv = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (first == 0 && (RISE !== 16'h0 || FALL !== 16'h0)) begin
        first = i; fv = RISE | FALL;
      end
    end
    checks++;
    if (first != DB + 2 || fv !== 16'h0120) begin
      errors++;
      $display("FAIL midreset_release got tick=%0d edges=%h want %0d 0120", first, fv, DB + 2);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        PIN_IN = PIN_IN ^ W'($urandom & $urandom);
        hold = $urandom_range(1, 7);
      end
      hold--;
      IRQ_CLR = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      tick();
      checks++;
      if (GPIOIN !== m_st || RISE !== m_rise || FALL !== m_fall ||
          IRQ !== m_irq || (RISE & FALL) !== '0) begin
        errors++;
        $display("FAIL rand cyc=%0d got g=%h r=%h f=%h i=%b want g=%h r=%h f=%h i=%b",
                 c, GPIOIN, RISE, FALL, IRQ, m_st, m_rise, m_fall, m_irq);
      end
    end
    IRQ_CLR = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_multi();
    test_irq_clr();
    test_reset_midcount();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_gpio_debounce.md
AHB_GPIO_DEBOUNCE -- requirements
Module: ahb_gpio_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the number of GPIO input bits.
REQ-002 The block SHALL have parameter DB_CYCLES, default 4 (legal 2..255), giving the consecutive synchronised cycles required to accept a new level.
REQ-003 The block SHALL have port HCLK, input, 1 bit: the single clock.
REQ-004 The block SHALL have port HRESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port PIN_IN, input, WIDTH bits: raw, asynchronous external pin levels.
REQ-006 The block SHALL have port GPIOIN, output, WIDTH bits: the debounced stable level, fed directly to the AHB GPIO slave GPIOIN input.
REQ-007 The block SHALL have port RISE, output, WIDTH bits: one-cycle pulse per bit on an accepted 0->1 change.
REQ-008 The block SHALL have port FALL, output, WIDTH bits: one-cycle pulse per bit on an accepted 1->0 change.
REQ-009 The block SHALL have port IRQ_CLR, input, WIDTH bits: per-bit clear of the sticky interrupt flags.
REQ-010 The block SHALL have port IRQ, output, 1 bit: OR of all sticky interrupt flags.

Function
REQ-011 Each PIN_IN bit SHALL pass through a 2-flop synchroniser (sync1, sync2); only sync2 is used downstream.
REQ-012 Each bit SHALL have an independent counter cnt of width ceil(log2(DB_CYCLES)).
REQ-013 When sync2 == stable, cnt SHALL load 0 on the next edge.
REQ-014 When sync2 != stable and cnt < DB_CYCLES-1, cnt SHALL increment by 1.
REQ-015 When sync2 != stable and cnt == DB_CYCLES-1, stable SHALL load sync2 and cnt SHALL load 0 on the same edge.
REQ-016 A PIN_IN change held steady SHALL appear on GPIOIN exactly DB_CYCLES+2 HCLK edges after the first edge that samples it (6 edges at default).
REQ-017 A sync2 excursion shorter than DB_CYCLES cycles SHALL leave GPIOIN unchanged, and the counter SHALL restart from 0 at the next excursion.
REQ-018 RISE/FALL for a bit SHALL be registered and high for exactly the one cycle in which GPIOIN for that bit first shows the new value.
REQ-019 RISE and FALL for the same bit SHALL never be high together.
REQ-020 cnt SHALL never exceed DB_CYCLES-1 and SHALL never wrap.
REQ-021 Bits SHALL be fully independent; simultaneous changes on several bits SHALL produce simultaneous pulses.

Reset
REQ-022 HRESET high SHALL asynchronously force sync1, sync2, stable, cnt, GPIOIN, RISE, FALL, all interrupt flags and IRQ to 0.
REQ-023 Release of HRESET SHALL be sampled on HCLK; a pin held at 1 through reset SHALL produce one RISE pulse DB_CYCLES+2 edges after release.
REQ-024 Reset asserted mid-count SHALL discard the count; no pulse SHALL be produced for the interrupted change.

Configuration
REQ-025 Macro DEBOUNCE_IRQ_EN defined: a per-bit sticky flag SHALL set on RISE or FALL, clear on IRQ_CLR, and IRQ SHALL be the registered OR of the flags.
REQ-026 If set and IRQ_CLR for a bit occur in the same cycle, set SHALL win.
REQ-027 Macro DEBOUNCE_IRQ_EN undefined: no flag registers SHALL exist, IRQ SHALL be tied 0 and IRQ_CLR SHALL be ignored; all other behaviour SHALL be unchanged.

Verification
REQ-028 Hold reset 5 cycles with PIN_IN=16'h0000, then release -> GPIOIN=16'h0000, RISE/FALL/IRQ=0 for 20 cycles.
REQ-029 Step PIN_IN to 16'h0001 after reset -> GPIOIN=16'h0001 exactly 6 edges later, RISE=16'h0001 for one cycle, and IRQ=1 one cycle after that (IRQ_EN build).
REQ-030 Apply 3-cycle glitch PIN_IN bit3=1 -> GPIOIN and RISE unchanged; then hold bit3=1 for 10 cycles -> single RISE=16'h0008.
REQ-031 Step PIN_IN 16'h00F0->16'h0F00 together -> same cycle RISE=16'h0F00, FALL=16'h00F0.
REQ-032 With flag 0 set, pulse IRQ_CLR=16'h0001 coincident with a new FALL on bit0 -> flag remains set, IRQ stays 1; a lone IRQ_CLR then drops IRQ to 0.
REQ-033 Assert HRESET at count 2 of a bit5 change -> all outputs 0 immediately, no FALL/RISE on bit5 until full DB_CYCLES+2 after release.
